// File: rtl/wdt_rst_req_module_if.sv
// rtl/wdt_rst_req_module_if.sv - watchdog control/status bundle
interface wdt_rst_req_module_if #(
    parameter int P_CNT_W = 16
);
    logic               i_en;
    logic               i_kick;
    logic               o_warn;
    logic               o_rst_req;
    logic [P_CNT_W-1:0] o_cnt;
    logic [7:0]         o_fire_cnt;
    logic               o_busy;

    modport master (
        output i_en, i_kick,
        input  o_warn, o_rst_req, o_cnt, o_fire_cnt, o_busy
    );

    modport slave (
        input  i_en, i_kick,
        output o_warn, o_rst_req, o_cnt, o_fire_cnt, o_busy
    );
endinterface

// File: rtl/wdt_rst_req_module.sv
// rtl/wdt_rst_req_module.sv - watchdog timer emitting a reset-request pulse
module wdt_rst_req_module #(
    parameter int P_TIMEOUT    = 20,
    parameter int P_WARN_CYCLE = 5,
    parameter int P_REQ_PULSE  = 4,
    parameter int P_HOLDOFF    = 8,
    parameter int P_CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    wdt_rst_req_module_if.slave   bus
);
    localparam int SUB_MAX   = (P_REQ_PULSE > P_HOLDOFF) ? P_REQ_PULSE : P_HOLDOFF;
    localparam int SUB_W     = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;
    localparam int HOLD_LAST = (P_HOLDOFF > 0) ? P_HOLDOFF - 1 : 0;

    localparam logic [P_CNT_W-1:0] WARN_AT    = P_CNT_W'(P_TIMEOUT - P_WARN_CYCLE - 1);
    localparam logic [P_CNT_W-1:0] FIRE_AT    = P_CNT_W'(P_TIMEOUT - 1);
    localparam logic [SUB_W-1:0]   PULSE_END  = SUB_W'(P_REQ_PULSE - 1);
    localparam logic [SUB_W-1:0]   HOLD_END   = SUB_W'(HOLD_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WARN,
        S_FIRE,
        S_HOLD
    } state_t;

    state_t             state, state_d;
    logic [P_CNT_W-1:0] cnt, cnt_d;
    logic               warn, warn_d;
    logic               req, req_d;
    logic               busy, busy_d;
    logic [7:0]         fire_cnt, fire_cnt_d;
    logic [SUB_W-1:0]   sub, sub_d;
    logic               do_fire;
    logic               do_release;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            warn     <= 1'b0;
            req      <= 1'b0;
            busy     <= 1'b0;
            fire_cnt <= '0;
            sub      <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            warn     <= warn_d;
            req      <= req_d;
            busy     <= busy_d;
            fire_cnt <= fire_cnt_d;
            sub      <= sub_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        warn_d     = warn;
        req_d      = req;
        busy_d     = busy;
        fire_cnt_d = fire_cnt;
        sub_d      = sub;
        do_fire    = 1'b0;
        do_release = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_d  = '0;
                warn_d = 1'b0;
                req_d  = 1'b0;
                busy_d = 1'b0;
                sub_d  = '0;
                if (bus.i_en) state_d = S_RUN;
            end
            // Disable beats kick, kick beats timeout.
            S_RUN: begin
                if (!bus.i_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (bus.i_kick) begin
                    cnt_d = '0;
                end else if (cnt == WARN_AT) begin
                    if (P_WARN_CYCLE > 0) begin
                        state_d = S_WARN;
                        cnt_d   = cnt + 1'b1;
                        warn_d  = 1'b1;
                    end else begin
                        do_fire = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_WARN: begin
                if (!bus.i_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    warn_d  = 1'b0;
                end else if (bus.i_kick) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    warn_d  = 1'b0;
                end else if (cnt == FIRE_AT) begin
                    do_fire = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_FIRE: begin
                if (sub == PULSE_END) begin
                    req_d = 1'b0;
                    sub_d = '0;
                    if (P_HOLDOFF > 0) state_d = S_HOLD;
                    else               do_release = 1'b1;
                end else begin
                    sub_d = sub + 1'b1;
                end
            end
            S_HOLD: begin
                if (sub == HOLD_END) do_release = 1'b1;
                else                 sub_d = sub + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_fire) begin
            state_d    = S_FIRE;
            cnt_d      = '0;
            warn_d     = 1'b0;
            req_d      = 1'b1;
            busy_d     = 1'b1;
            sub_d      = '0;
            fire_cnt_d = (fire_cnt != 8'hFF) ? fire_cnt + 8'd1 : fire_cnt;
        end

        // Leaving the busy period re-arms only if still enabled.
        if (do_release) begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            sub_d   = '0;
            state_d = bus.i_en ? S_RUN : S_IDLE;
        end
    end

    assign bus.o_warn     = warn;
    assign bus.o_rst_req  = req;
    assign bus.o_cnt      = cnt;
    assign bus.o_fire_cnt = fire_cnt;
    assign bus.o_busy     = busy;
endmodule

// File: tb/tb_wdt_rst_req_module.sv
// tb/tb_wdt_rst_req_module.sv - randomized bench with behavioural watchdog model
module tb_wdt_rst_req_module;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wdt_rst_req_module_if #(.P_CNT_W(16)) bus0 ();
    wdt_rst_req_module_if #(.P_CNT_W(16)) bus1 ();

    wdt_rst_req_module dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0.slave)
    );

    wdt_rst_req_module #(
        .P_TIMEOUT    (20),
        .P_WARN_CYCLE (0),
        .P_REQ_PULSE  (1),
        .P_HOLDOFF    (0),
        .P_CNT_W      (16)
    ) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    int checks   = 0;
    int failures = 0;

    int cfg_t [2] = '{20, 20};
    int cfg_w [2] = '{5, 0};
    int cfg_p [2] = '{4, 1};
    int cfg_h [2] = '{8, 0};

    // armed: counting toward a timeout; age: edges since arm/kick;
    // busy_left: remaining pulse+holdoff cycles after a fire.
    bit armed     [2];
    int age       [2];
    int busy_left [2];
    int fires     [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit k);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                armed[i] = 0; age[i] = 0; busy_left[i] = 0; fires[i] = 0;
            end else if (busy_left[i] > 0) begin
                busy_left[i]--;
                if (busy_left[i] == 0) begin
                    armed[i] = e;
                    age[i]   = 0;
                end
            end else if (!armed[i]) begin
                if (e) begin
                    armed[i] = 1; age[i] = 0;
                end
            end else if (!e) begin
                armed[i] = 0; age[i] = 0;
            end else if (k) begin
                age[i] = 0;
            end else if (age[i] + 1 == cfg_t[i]) begin
                armed[i]     = 0;
                age[i]       = 0;
                busy_left[i] = cfg_p[i] + cfg_h[i];
                if (fires[i] < 255) fires[i]++;
            end else begin
                age[i]++;
            end
        end
    endtask

    task automatic check_one(input int i, input logic w, input logic rq, input logic [15:0] c,
                             input logic [7:0] f, input logic b);
        bit exp_warn;
        exp_warn = armed[i] && cfg_w[i] > 0 && age[i] >= cfg_t[i] - cfg_w[i];
        check_eq($sformatf("cfg%0d warn", i), {31'd0, w}, {31'd0, exp_warn});
        check_eq($sformatf("cfg%0d rst_req", i), {31'd0, rq}, (busy_left[i] > cfg_h[i]) ? 1 : 0);
        check_eq($sformatf("cfg%0d cnt", i), {16'd0, c}, armed[i] ? age[i] : 0);
        check_eq($sformatf("cfg%0d fire_cnt", i), {24'd0, f}, fires[i]);
        check_eq($sformatf("cfg%0d busy", i), {31'd0, b}, (busy_left[i] > 0) ? 1 : 0);
    endtask

    initial begin
        bit r, e, k;
        bit rst_done  = 0;
        bit post_rst  = 0;
        int max_cnt   = 0;
        int alarms    = 0;
        int n_total   = 3 + 60 + 100 + 2000 + 6600;

        for (int i = 0; i < 2; i++) begin
            armed[i] = 0; age[i] = 0; busy_left[i] = 0; fires[i] = 0;
        end
        rst       = 1'b1;
        bus0.i_en = 1'b0; bus0.i_kick = 1'b0;
        bus1.i_en = 1'b0; bus1.i_kick = 1'b0;
        model_step(1, 0, 0);

        for (int n = 0; n < n_total; n++) begin
            @(negedge clk);
            check_one(0, bus0.o_warn, bus0.o_rst_req, bus0.o_cnt, bus0.o_fire_cnt, bus0.o_busy);
            check_one(1, bus1.o_warn, bus1.o_rst_req, bus1.o_cnt, bus1.o_fire_cnt, bus1.o_busy);

            if (post_rst) begin
                check_eq("rst_mid_fire rst_req", {31'd0, bus0.o_rst_req}, 0);
                check_eq("rst_mid_fire fire_cnt", {24'd0, bus0.o_fire_cnt}, 0);
                check_eq("rst_mid_fire busy", {31'd0, bus0.o_busy}, 0);
                post_rst = 0;
            end

            if (n >= 80 && n < 163) begin
                if (int'(bus0.o_cnt) > max_cnt) max_cnt = int'(bus0.o_cnt);
                if (bus0.o_warn || bus0.o_rst_req) alarms++;
            end

            r = 0; e = 1; k = 0;
            if (n < 3) begin
                r = 1; e = 0;
            end else if (n < 63) begin
                k = 0;
            end else if (n < 163) begin
                k = ((n - 63) % 10 == 9);
            end else if (n < 2163) begin
                e = ($urandom_range(0, 19) != 0);
                k = ($urandom_range(0, 24) == 0);
                r = ($urandom_range(0, 299) == 0);
                if (!rst_done && busy_left[0] == cfg_p[0] + cfg_h[0] - 1) begin
                    r = 1; rst_done = 1; post_rst = 1;
                end
            end

            rst       = r;
            bus0.i_en = e; bus0.i_kick = k;
            bus1.i_en = e; bus1.i_kick = k;
            model_step(r, e, k);
        end

        @(negedge clk);
        check_eq("kick_every_10 max_cnt_ok", (max_cnt <= 10) ? 1 : 0, 1);
        check_eq("kick_every_10 alarms", alarms, 0);
        check_eq("cfg1 fire_cnt saturated", {24'd0, bus1.o_fire_cnt}, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
